l2_multiway_data_array: RTL and testbench
=========================================

Name: l2_multiway_data_array

Overview:
- Parametrised successor to the single-way L2 data array: stores `2**s_way` ways × `2**s_index` sets of `s_line`-bit lines.
- Byte-masked writes to one selected way; reads of one selected way with a configurable latency of 1 or 2 cycles and a response-valid flag.
- Write-first forwarding on a same-cycle, same-location read and write.
- Built-in sequential clear engine: zeroes the whole array after reset or on request, and reports busy while it runs.
- Sits between the L2 controller (way/index/mask) and the L2 tag/LRU logic.

Parameters:
- `s_offset`, 5: log2 of line size in bytes.
- `s_index`, 3: log2 of set count.
- `s_way`, 1: log2 of way count; minimum 1.
- `s_mask`, `2**s_offset`: bytes per line, i.e. write-mask width.
- `s_line`, `8*s_mask`: line width in bits.
- `READ_LATENCY`, 1: read latency in cycles, from accept to `resp_valid`. Legal values are 1 and 2; any other value is a compile-time error.

Ports:
- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `read` in 1: read request for (`way_sel`, `index`).
- `write_en` in `s_mask`: byte write enables for (`way_sel`, `index`); 0 means no write.
- `way_sel` in `s_way`: target way for both read and write.
- `index` in `s_index`: target set.
- `datain` in `s_line`: write data; byte i is `datain[8i+7:8i]`.
- `clear_req` in 1: one-cycle pulse requesting a full-array clear.
- `busy` out 1: clear engine active; requests are ignored.
- `dataout` out `s_line`: read data.
- `resp_valid` out 1: `dataout` is valid this cycle, one-cycle pulse per accepted read.

Behaviour:
- **Reset (`rst_n`=0, asynchronous):**
  - `dataout`=0, `resp_valid`=0, read pipeline valid bits=0.
  - FSM=CLEAR, clear counter=0, `busy`=1.
  - Array storage is not reset directly; the CLEAR sweep zeroes it after reset release.
- **FSM states: CLEAR, IDLE.**
  - CLEAR: each cycle, all ways of set `clear_cnt` are written to 0 and `clear_cnt` increments.
  - CLEAR exits when `clear_cnt == 2**s_index - 1` is written; the next cycle is IDLE with `busy`=0.
  - Sweep length is exactly `2**s_index` cycles, i.e. 8 at defaults.
  - IDLE: `clear_req`=1 moves to CLEAR next cycle with `clear_cnt`=0. `busy` rises the cycle after `clear_req`.
- **Request acceptance:**
  - Requests are accepted only when FSM=IDLE, including the cycle `clear_req` is sampled.
  - `read`, `write_en` and `clear_req` while `busy`=1 are dropped silently: no write, no `resp_valid`.
- **Write:**
  - In IDLE, for each i with `write_en[i]`=1, byte i of `data[way_sel][index]` takes `datain` byte i at the clock edge.
  - Unmasked bytes and all other ways are unchanged.
- **Read, `READ_LATENCY`=1:**
  - Read accepted at edge N; `dataout`/`resp_valid` update at edge N, so they are visible in the cycle after the request.
  - Simultaneous read and write to the same way and index is write-first: `dataout` is the merged line (new bytes where `write_en`=1, old bytes elsewhere).
  - A write to a different way or index does not affect the read.
- **Read, `READ_LATENCY`=2:**
  - The merged line is captured into an internal stage register at edge N and moved to `dataout` at edge N+1.
  - A write at N+1 to the same location is NOT forwarded; `dataout` shows the value as of edge N.
- **Throughput:** back-to-back reads every cycle are supported at either latency; responses come in request order.
- **Output hold:** `dataout` holds its last value when no response is issued.
- **Reset mid-sweep or mid-read:** pending responses are discarded (`resp_valid` never asserts for them) and the sweep restarts from set 0.
- **`clear_req` with a read in the same cycle:** the read is accepted and its response is delivered on schedule even though `busy`=1 by then.
- **`clear_req` with a write in the same cycle:** the write is performed, then overwritten by the sweep.

Test Plan (defaults unless noted):
- **Reset sweep:** release `rst_n` → `busy`=1 for exactly 8 cycles, then 0; a read of way 1, set 7 then returns 0 with `resp_valid`=1 one cycle later.
- **Byte-masked write:** write `write_en`=0x0000_000F, `datain` bytes 0..3 = 0xDEADBEEF, way 0, set 2; read way 0, set 2 → low 32 bits 0xDEADBEEF, rest 0. Read way 1, set 2 → all 0.
- **Write-first collision:** line holds all-0xAA; same cycle: read plus write `write_en`=0x1, `datain` byte 0 = 0x55 → `dataout` byte 0 = 0x55, bytes 1..31 = 0xAA.
- **`READ_LATENCY`=2:** reads to sets 0,1,2 on three consecutive cycles → `resp_valid` high on cycles +2,+3,+4 with matching lines. A same-location write in the cycle after a read is not seen in that read's data.
- **Clear request:** fill all 16 lines with 0xFF; pulse `clear_req` → `busy` high for 8 cycles. A read and a write issued during `busy` produce no `resp_valid` and no write. All lines read 0 afterwards.
- **Reset mid-operation:** assert `rst_n`=0 at sweep cycle 4 and during a pending `READ_LATENCY`=2 read → no `resp_valid`; sweep restarts and takes the full 8 cycles.

Source files
------------

// File: rtl/l2_multiway_data_array.sv
// l2_multiway_data_array: multi-way L2 line store with byte-masked writes, 1/2-cycle reads and a clear sweep
module l2_multiway_data_array #(
  parameter int s_offset = 5,
  parameter int s_index = 3,
  parameter int s_way = 1,
  parameter int s_mask = 2**s_offset,
  parameter int s_line = 8*s_mask,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              read,
  input  logic [s_mask-1:0] write_en,
  input  logic [s_way-1:0]  way_sel,
  input  logic [s_index-1:0] index,
  input  logic [s_line-1:0] datain,
  input  logic              clear_req,
  output logic              busy,
  output logic [s_line-1:0] dataout,
  output logic              resp_valid
);
  typedef enum logic {CLEAR, IDLE} state_t;
  state_t state;
  logic [s_index-1:0] clear_cnt;
  logic [s_line-1:0] mem [2**s_way][2**s_index];
  logic [s_line-1:0] merged;
  logic idle, rd_acc;
  assign idle = state == IDLE;
  assign busy = ~idle;
  assign rd_acc = idle & read;
  // write-first view of the addressed line, shared by the write port and the read path
  always_comb begin
    merged = mem[way_sel][index];
    for (int i = 0; i < s_mask; i++)
      merged[8*i +: 8] = write_en[i] ? datain[8*i +: 8] : merged[8*i +: 8];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CLEAR;
      clear_cnt <= '0;
    end else if (!idle) begin
      clear_cnt <= clear_cnt + 1'b1;
      state <= (clear_cnt == '1) ? IDLE : CLEAR;
    end else if (clear_req) begin
      state <= CLEAR;
      clear_cnt <= '0;
    end
  end
  always_ff @(posedge clk) begin
    if (!idle)
      for (int w = 0; w < 2**s_way; w++) mem[w[s_way-1:0]][clear_cnt] <= '0;
    else if (|write_en)
      mem[way_sel][index] <= merged;
  end
  if (READ_LATENCY == 1) begin : g_l1
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        resp_valid <= 1'b0;
        dataout <= '0;
      end else begin
        resp_valid <= rd_acc;
        if (rd_acc) dataout <= merged;
      end
    end
  end else if (READ_LATENCY == 2) begin : g_l2
    logic stage_v;
    logic [s_line-1:0] stage;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        stage_v <= 1'b0;
        stage <= '0;
        resp_valid <= 1'b0;
        dataout <= '0;
      end else begin
        stage_v <= rd_acc;
        if (rd_acc) stage <= merged;
        resp_valid <= stage_v;
        if (stage_v) dataout <= stage;
      end
    end
  end else begin : g_bad
    $error("READ_LATENCY must be 1 or 2");
  end
endmodule

// File: tb/tb_l2_multiway_data_array.sv
// tb_l2_multiway_data_array: scoreboard bench driving latency-1 and latency-2 instances in lockstep
module tb_l2_multiway_data_array;
  localparam int L = 256, M = 32, SETS = 8, SWEEP = 8;
  typedef struct {logic [L-1:0] d; int due;} exp_t;
  logic clk = 0, rst_n = 0, read = 0, clear_req = 0, way_sel = 0;
  logic [M-1:0] write_en = 0;
  logic [2:0] index = 0;
  logic [L-1:0] datain = 0;
  logic busy1, busy2, rv1, rv2;
  logic [L-1:0] do1, do2;
  logic [L-1:0] mem_m [2][SETS];
  exp_t q [2][$];
  int cyc = 0, m_clear = 0, checks = 0, failures = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  l2_multiway_data_array #(.READ_LATENCY(1)) d1 (.clk(clk), .rst_n(rst_n), .read(read),
    .write_en(write_en), .way_sel(way_sel), .index(index), .datain(datain),
    .clear_req(clear_req), .busy(busy1), .dataout(do1), .resp_valid(rv1));
  l2_multiway_data_array #(.READ_LATENCY(2)) d2 (.clk(clk), .rst_n(rst_n), .read(read),
    .write_en(write_en), .way_sel(way_sel), .index(index), .datain(datain),
    .clear_req(clear_req), .busy(busy2), .dataout(do2), .resp_valid(rv2));
  task automatic chk(input string n, input logic [L-1:0] a, input logic [L-1:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", n, cyc, a, e);
    end
  endtask
  task automatic mon(input int k, input logic [L-1:0] d);
    exp_t e;
    checks++;
    if (q[k].size() == 0) begin
      failures++;
      $display("FAIL resp_unexpected lat=%0d cyc=%0d got=%0h", k + 1, cyc, d);
    end else begin
      e = q[k].pop_front();
      if (d !== e.d || cyc != e.due) begin
        failures++;
        $display("FAIL resp lat=%0d cyc=%0d due=%0d got=%0h exp=%0h", k + 1, cyc, e.due, d, e.d);
      end
    end
  endtask
  always @(negedge clk) if (rst_n && rv1) mon(0, do1);
  always @(negedge clk) if (rst_n && rv2) mon(1, do2);
  function automatic logic [L-1:0] rnd();
    logic [L-1:0] r;
    for (int i = 0; i < L / 32; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction
  task automatic zero_model();
    for (int w = 0; w < 2; w++) for (int s = 0; s < SETS; s++) mem_m[w][s] = '0;
  endtask
  // one clock: model decides acceptance from its own busy count, then the edge happens
  task automatic tick();
    logic [L-1:0] mg;
    @(negedge clk);
    chk("busy_l1", busy1, m_clear > 0);
    chk("busy_l2", busy2, m_clear > 0);
    if (m_clear > 0) m_clear--;
    else begin
      mg = mem_m[way_sel][index];
      for (int i = 0; i < M; i++) if (write_en[i]) mg[8*i +: 8] = datain[8*i +: 8];
      if (read) begin
        q[0].push_back('{mg, cyc + 1});
        q[1].push_back('{mg, cyc + 2});
      end
      mem_m[way_sel][index] = mg;
      if (clear_req) begin
        m_clear = SWEEP;
        zero_model();
      end
    end
    @(posedge clk);
    #1;
    read = 0; write_en = 0; clear_req = 0;
  endtask
  task automatic op(input bit r, input logic [M-1:0] we, input bit w, input int s,
                    input logic [L-1:0] d, input bit c = 0);
    read = r; write_en = we; way_sel = w; index = s[2:0]; datain = d; clear_req = c;
    tick();
  endtask
  task automatic reset_pulse();
    rst_n = 0;
    read = 0; write_en = 0; clear_req = 0;
    q[0].delete(); q[1].delete();
    zero_model();
    #1;
    chk("rst_dataout_l1", do1, 0); chk("rst_dataout_l2", do2, 0);
    chk("rst_valid_l1", rv1, 0); chk("rst_valid_l2", rv2, 0);
    chk("rst_busy_l1", busy1, 1); chk("rst_busy_l2", busy2, 1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    m_clear = SWEEP;
  endtask
  initial begin
    logic [L-1:0] d;
    reset_pulse();
    repeat (SWEEP + 1) tick();
    op(1, 0, 1, 7, 0);
    op(0, 32'hF, 0, 2, {224'h0, 32'hDEADBEEF});
    op(1, 0, 0, 2, 0);
    op(1, 0, 1, 2, 0);
    op(0, '1, 1, 3, {32{8'hAA}});
    d = rnd(); d[7:0] = 8'h55;
    op(1, 32'h1, 1, 3, d);
    op(1, 0, 1, 3, 0);
    for (int s = 0; s < 3; s++) op(1, 0, 0, s, 0);
    op(1, 0, 0, 5, 0);
    op(0, '1, 0, 5, rnd());
    op(1, 0, 0, 5, 0);
    for (int n = 0; n < 300; n++)
      op($urandom_range(0, 1), ($urandom_range(0, 2) == 0) ? 32'h0 : $urandom, $urandom_range(0, 1),
         $urandom_range(0, SETS - 1), rnd(), $urandom_range(0, 39) == 0);
    while (m_clear > 0) tick();
    for (int w = 0; w < 2; w++) for (int s = 0; s < SETS; s++) op(0, '1, w, s, '1);
    op(1, 0, 0, 6, 0, 1);
    op(1, 0, 0, 1, 0);
    op(0, '1, 1, 4, rnd());
    repeat (SWEEP - 2) tick();
    for (int w = 0; w < 2; w++) for (int s = 0; s < SETS; s++) op(1, 0, w, s, 0);
    op(0, 0, 0, 0, 0, 1);
    repeat (4) tick();
    reset_pulse();
    repeat (SWEEP) tick();
    op(1, 0, 1, 5, 0);
    op(0, '1, 0, 0, rnd());
    op(1, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    reset_pulse();
    repeat (SWEEP) tick();
    op(1, 0, 0, 0, 0);
    repeat (4) tick();
    chk("pending_l1", q[0].size(), 0);
    chk("pending_l2", q[1].size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
